// File: rtl/rtc_secuenciador_param.sv
// RTC transaction sequencer: init burst, read sweeps, mode-dependent config reads
// and write-back, with a one-outstanding handshake, watchdog and sweep gap.
module rtc_secuenciador_param #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TO_CYC  = 1023,
    parameter int GAP_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_flag_done,
    input  logic              in_sw1,
    input  logic              in_sw2,
    output logic [1:0]        out_funcion_conf,
    output logic              out_en_funcion_rtc,
    output logic              out_funcion_w_r,
    output logic [ADDR_W-1:0] out_addr_ram_rtc,
    output logic [DATA_W-1:0] out_dato_inicio,
    output logic              out_flag_inicio,
    output logic [3:0]        out_idx,
    output logic [2:0]        out_state,
    output logic              out_timeout_err
);

    localparam int WD_W  = $clog2(TO_CYC + 1);
    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_CONF  = 3'd4
    } state_t;

    state_t            r_state;
    logic [1:0]        r_conf;
    logic [1:0]        r_last_mode;
    logic              r_en;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_flag;
    logic [3:0]        r_idx;
    logic              r_timeout_err;
    logic [WD_W-1:0]   r_wd;
    logic [GAP_W-1:0]  r_gap;

    logic [3:0]        w_len;
    logic              w_last;
    logic              w_wd_exp;
    logic [7:0]        w_addr;
    logic [7:0]        w_data;

    // Register address for a table entry; CONF and WRITE tables follow last_mode.
    function automatic logic [7:0] f_addr(input state_t st, input logic [1:0] md,
                                          input logic [3:0] ix);
        logic [7:0] a;
        a = 8'h00;
        case (st)
            ST_INIT: begin
                case (ix)
                    4'd0, 4'd1: a = 8'h02;
                    4'd2:       a = 8'h10;
                    default:    a = 8'h00;
                endcase
            end
            ST_READ: begin
                case (ix)
                    4'd0:                                   a = 8'hF0;
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: a = 8'h20 + {4'h0, ix};
                    4'd8, 4'd9, 4'd10:                      a = 8'h39 + {4'h0, ix};
                    default:                                a = 8'h00;
                endcase
            end
            ST_CONF: begin
                case (md)
                    2'b01: begin
                        case (ix)
                            4'd0:             a = 8'hF2;
                            4'd1, 4'd2, 4'd3: a = 8'h40 + {4'h0, ix};
                            default:          a = 8'h00;
                        endcase
                    end
                    2'b10: begin
                        case (ix)
                            4'd0:             a = 8'hF1;
                            4'd1, 4'd2, 4'd3: a = 8'h20 + {4'h0, ix};
                            4'd4:             a = 8'hF2;
                            4'd5, 4'd6, 4'd7: a = 8'h3C + {4'h0, ix};
                            default:          a = 8'h00;
                        endcase
                    end
                    2'b11: begin
                        case (ix)
                            4'd0:    a = 8'hF1;
                            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: a = 8'h20 + {4'h0, ix};
                            default: a = 8'h00;
                        endcase
                    end
                    default: a = 8'h00;
                endcase
            end
            ST_WRITE: begin
                if (md == 2'b11) begin
                    case (ix)
                        4'd0, 4'd1, 4'd2: a = 8'h41 + {4'h0, ix};
                        4'd3:             a = 8'hF2;
                        default:          a = 8'h00;
                    endcase
                end else begin
                    case (ix)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: a = 8'h21 + {4'h0, ix};
                        4'd7:    a = 8'hF1;
                        default: a = 8'h00;
                    endcase
                end
            end
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    // Number of entries in the table currently being walked.
    function automatic logic [3:0] f_len(input state_t st, input logic [1:0] md);
        logic [3:0] n;
        case (st)
            ST_INIT:  n = 4'd3;
            ST_READ:  n = 4'd11;
            ST_CONF:  n = (md == 2'b01) ? 4'd4 : 4'd8;
            ST_WRITE: n = (md == 2'b11) ? 4'd4 : 4'd8;
            default:  n = 4'd1;
        endcase
        return n;
    endfunction

    // Init burst write data.
    function automatic logic [7:0] f_data(input logic [3:0] ix);
        logic [7:0] d;
        case (ix)
            4'd0:    d = 8'h10;
            4'd1:    d = 8'h00;
            4'd2:    d = 8'hD2;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    assign w_len    = f_len(r_state, r_last_mode);
    assign w_last   = (r_idx == (w_len - 4'd1));
    assign w_wd_exp = (r_wd == WD_W'(TO_CYC - 1));
    assign w_addr   = f_addr(r_state, r_last_mode, r_idx);
    assign w_data   = f_data(r_idx);

    // Sequencer: issue/close handshake, watchdog, sweep gap and state walk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_conf        <= 2'b00;
            r_last_mode   <= 2'b01;
            r_en          <= 1'b0;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_flag        <= 1'b0;
            r_idx         <= 4'd0;
            r_timeout_err <= 1'b0;
            r_wd          <= '0;
            r_gap         <= '0;
        end else begin
            r_conf <= {in_sw2, in_sw1};
            if (r_en) begin
                // Done wins over a simultaneous watchdog expiry.
                if (in_flag_done || w_wd_exp) begin
                    r_en          <= 1'b0;
                    r_wr          <= 1'b0;
                    r_addr        <= '0;
                    r_data        <= '0;
                    r_flag        <= 1'b0;
                    r_wd          <= '0;
                    r_timeout_err <= r_timeout_err | ~in_flag_done;
                    case (r_state)
                        ST_INIT, ST_WRITE: begin
                            if (w_last) begin
                                r_state <= ST_READ;
                                r_idx   <= 4'd0;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end
                        ST_READ: begin
                            if (w_last) begin
                                r_idx <= 4'd0;
                                if (r_conf != 2'b00) begin
                                    r_last_mode <= r_conf;
                                    r_state     <= ST_CONF;
                                end else begin
                                    r_gap <= GAP_W'(GAP_CYC);
                                end
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end
                        ST_CONF: begin
                            if (r_conf != r_last_mode) begin
                                r_idx <= 4'd0;
                                if (r_conf == 2'b00) begin
                                    r_state <= ST_WRITE;
                                end else begin
                                    r_last_mode <= r_conf;
                                end
                            end else if (w_last) begin
                                r_idx <= 4'd0;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_idx   <= 4'd0;
                        end
                    endcase
                end else begin
                    r_wd <= r_wd + WD_W'(1);
                end
            end else begin
                r_wd <= '0;
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_INIT;
                        r_idx   <= 4'd0;
                    end
                    ST_INIT, ST_READ, ST_WRITE, ST_CONF: begin
                        if ((r_state == ST_CONF) && (r_conf != r_last_mode)) begin
                            r_idx <= 4'd0;
                            if (r_conf == 2'b00) begin
                                r_state <= ST_WRITE;
                            end else begin
                                r_last_mode <= r_conf;
                            end
                        end else if (r_gap != '0) begin
                            r_gap <= r_gap - GAP_W'(1);
                        end else begin
                            r_en   <= 1'b1;
                            r_addr <= ADDR_W'(w_addr);
                            r_wr   <= (r_state == ST_INIT) || (r_state == ST_WRITE);
                            r_data <= (r_state == ST_INIT) ? DATA_W'(w_data) : '0;
                            r_flag <= (r_state == ST_INIT);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_idx   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign out_funcion_conf   = r_conf;
    assign out_en_funcion_rtc = r_en;
    assign out_funcion_w_r    = r_wr;
    assign out_addr_ram_rtc   = r_addr;
    assign out_dato_inicio    = r_data;
    assign out_flag_inicio    = r_flag;
    assign out_idx            = r_idx;
    assign out_state          = r_state;
    assign out_timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_rtc_secuenciador_param.sv
// Directed scoreboard bench for rtc_secuenciador_param (TO_CYC=20, GAP_CYC=4).
module tb_rtc_secuenciador_param;

    localparam int TO = 20;
    localparam int GAP = 4;

    logic       clk;
    logic       reset;
    logic       in_flag_done;
    logic       in_sw1;
    logic       in_sw2;
    logic [1:0] out_funcion_conf;
    logic       out_en_funcion_rtc;
    logic       out_funcion_w_r;
    logic [7:0] out_addr_ram_rtc;
    logic [7:0] out_dato_inicio;
    logic       out_flag_inicio;
    logic [3:0] out_idx;
    logic [2:0] out_state;
    logic       out_timeout_err;

    rtc_secuenciador_param #(.ADDR_W(8), .DATA_W(8), .TO_CYC(TO), .GAP_CYC(GAP)) dut (
        .clk(clk), .reset(reset), .in_flag_done(in_flag_done),
        .in_sw1(in_sw1), .in_sw2(in_sw2),
        .out_funcion_conf(out_funcion_conf), .out_en_funcion_rtc(out_en_funcion_rtc),
        .out_funcion_w_r(out_funcion_w_r), .out_addr_ram_rtc(out_addr_ram_rtc),
        .out_dato_inicio(out_dato_inicio), .out_flag_inicio(out_flag_inicio),
        .out_idx(out_idx), .out_state(out_state), .out_timeout_err(out_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] data;
        logic       flag;
        logic [2:0] st;
        logic [3:0] idx;
        int         idle;
        int         dly;
        logic       sw_set;
        logic [1:0] sw;
    } txn_t;

    txn_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] rd_tab [11] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};
    logic [7:0] c11_tab [8] = '{8'hF1, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    logic [7:0] c10_tab [8] = '{8'hF1, 8'h21, 8'h22, 8'h23, 8'hF2, 8'h41, 8'h42, 8'h43};
    logic [7:0] c01_tab [4] = '{8'hF2, 8'h41, 8'h42, 8'h43};
    logic [7:0] w11_tab [4] = '{8'h41, 8'h42, 8'h43, 8'hF2};
    logic [7:0] w10_tab [8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'hF1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic wr, input logic [7:0] d,
                        input logic fl, input logic [2:0] st, input logic [3:0] ix,
                        input int idle, input int dly, input logic ss, input logic [1:0] sv);
        txn_t t;
        t.addr = a; t.wr = wr; t.data = d; t.flag = fl; t.st = st; t.idx = ix;
        t.idle = idle; t.dly = dly; t.sw_set = ss; t.sw = sv;
        sb.push_back(t);
    endtask

    task automatic push_rd(input int ix, input int idle, input int dly,
                           input logic ss, input logic [1:0] sv);
        push(rd_tab[ix], 1'b0, 8'h00, 1'b0, 3'd3, 4'(ix), idle, dly, ss, sv);
    endtask

    // Wait for the next issue, compare against the scoreboard head, then answer it.
    task automatic serve_one();
        txn_t e;
        int zeros;
        int hi;
        logic got;
        e = sb.pop_front();
        zeros = 0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_en_funcion_rtc) begin
                got = 1'b1;
                break;
            end
            zeros++;
        end
        chk("en_rise", 32'(got), 32'd1);
        if (e.idle >= 0) chk("idle_cycles", 32'(zeros + 1), 32'(e.idle));
        chk("addr", 32'(out_addr_ram_rtc), 32'(e.addr));
        chk("w_r", 32'(out_funcion_w_r), 32'(e.wr));
        chk("dato_inicio", 32'(out_dato_inicio), 32'(e.data));
        chk("flag_inicio", 32'(out_flag_inicio), 32'(e.flag));
        chk("state", 32'(out_state), 32'(e.st));
        chk("idx", 32'(out_idx), 32'(e.idx));
        if (e.dly == 0) begin
            hi = 1;
            for (int c = 0; c < TO + 10; c++) begin
                @(negedge clk);
                if (!out_en_funcion_rtc) break;
                hi++;
            end
            chk("wd_en_high_cycles", 32'(hi), 32'(TO));
            chk("timeout_err_set", 32'(out_timeout_err), 32'd1);
        end else begin
            for (int c = 1; c < e.dly; c++) begin
                @(negedge clk);
                if (c == 1 && e.sw_set) {in_sw2, in_sw1} = e.sw;
                if (c == 2 && e.sw_set) chk("funcion_conf", 32'(out_funcion_conf), 32'(e.sw));
                chk("en_held", 32'(out_en_funcion_rtc), 32'd1);
                chk("addr_stable", 32'(out_addr_ram_rtc), 32'(e.addr));
            end
            in_flag_done = 1'b1;
            @(negedge clk);
            in_flag_done = 1'b0;
            chk("en_fall", 32'(out_en_funcion_rtc), 32'd0);
            chk("addr_idle_zero", 32'(out_addr_ram_rtc), 32'd0);
        end
    endtask

    task automatic run_sb();
        while (sb.size() > 0) serve_one();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, 32'(out_en_funcion_rtc), 32'd0);
        chk({tag, "_addr"}, 32'(out_addr_ram_rtc), 32'd0);
        chk({tag, "_wr"}, 32'(out_funcion_w_r), 32'd0);
        chk({tag, "_data"}, 32'(out_dato_inicio), 32'd0);
        chk({tag, "_flag"}, 32'(out_flag_inicio), 32'd0);
        chk({tag, "_idx"}, 32'(out_idx), 32'd0);
        chk({tag, "_state"}, 32'(out_state), 32'd0);
        chk({tag, "_conf"}, 32'(out_funcion_conf), 32'd0);
        chk({tag, "_err"}, 32'(out_timeout_err), 32'd0);
    endtask

    initial begin
        logic got;
        reset = 1'b0;
        in_flag_done = 1'b0;
        in_sw1 = 1'b0;
        in_sw2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_state", 32'(out_state), 32'd1);
        chk("post_reset_en", 32'(out_en_funcion_rtc), 32'd0);

        // Init burst then first sweep; idx 5 returns done on the watchdog expiry cycle.
        push(8'h02, 1'b1, 8'h10, 1'b1, 3'd1, 4'd0, 1, 3, 1'b0, 2'b00);
        push(8'h02, 1'b1, 8'h00, 1'b1, 3'd1, 4'd1, 1, 3, 1'b0, 2'b00);
        push(8'h10, 1'b1, 8'hD2, 1'b1, 3'd1, 4'd2, 1, 3, 1'b0, 2'b00);
        for (int i = 0; i < 11; i++) push_rd(i, 1, (i == 5) ? TO : 3, 1'b0, 2'b00);
        run_sb();
        chk("done_at_expiry_no_err", 32'(out_timeout_err), 32'd0);

        // Second sweep after the gap; done withheld on addr 23.
        for (int i = 0; i < 11; i++) push_rd(i, (i == 0) ? GAP + 1 : 1, (i == 3) ? 0 : 3, 1'b0, 2'b00);
        // Third sweep, mode 11 requested mid-sweep.
        for (int i = 0; i < 11; i++) push_rd(i, (i == 0) ? GAP + 1 : 1, 3, (i == 5), 2'b11);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 8; i++) push(c11_tab[i], 1'b0, 8'h00, 1'b0, 3'd4, 4'(i), 1, 3, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) push(c11_tab[i], 1'b0, 8'h00, 1'b0, 3'd4, 4'(i), 1, 3, (i == 2), 2'b00);
        for (int i = 0; i < 4; i++) push(w11_tab[i], 1'b1, 8'h00, 1'b0, 3'd2, 4'(i), 1, 3, 1'b0, 2'b00);
        for (int i = 0; i < 11; i++) push_rd(i, 1, 3, (i == 9), 2'b01);
        for (int i = 0; i < 3; i++) push(c01_tab[i], 1'b0, 8'h00, 1'b0, 3'd4, 4'(i), 1, 3, (i == 2), 2'b10);
        for (int i = 0; i < 8; i++) push(c10_tab[i], 1'b0, 8'h00, 1'b0, 3'd4, 4'(i), 1, 3, (i == 7), 2'b00);
        push(w10_tab[0], 1'b1, 8'h00, 1'b0, 3'd2, 4'd0, 1, 3, 1'b0, 2'b00);
        run_sb();
        chk("timeout_err_sticky", 32'(out_timeout_err), 32'd1);
        chk("conf_back_to_00", 32'(out_funcion_conf), 32'd0);

        // Reset while the second WRITE transaction is outstanding.
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_en_funcion_rtc) begin
                got = 1'b1;
                break;
            end
        end
        chk("write2_en", 32'(got), 32'd1);
        chk("write2_addr", 32'(out_addr_ram_rtc), 32'(w10_tab[1]));
        chk("write2_idx", 32'(out_idx), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        in_flag_done = 1'b1;
        @(negedge clk);
        in_flag_done = 1'b0;
        chk("stray_done_in_reset", 32'(out_en_funcion_rtc), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("restart_state", 32'(out_state), 32'd1);
        chk("restart_en_low", 32'(out_en_funcion_rtc), 32'd0);
        in_flag_done = 1'b1;
        @(negedge clk);
        in_flag_done = 1'b0;
        chk("stray_done_ignored_en", 32'(out_en_funcion_rtc), 32'd1);
        chk("stray_done_ignored_idx", 32'(out_idx), 32'd0);
        chk("restart_addr", 32'(out_addr_ram_rtc), 32'h02);
        chk("restart_data", 32'(out_dato_inicio), 32'h10);
        chk("restart_flag", 32'(out_flag_inicio), 32'd1);
        repeat (2) @(negedge clk);
        in_flag_done = 1'b1;
        @(negedge clk);
        in_flag_done = 1'b0;
        chk("restart_close_en", 32'(out_en_funcion_rtc), 32'd0);
        chk("restart_close_idx", 32'(out_idx), 32'd1);
        push(8'h02, 1'b1, 8'h00, 1'b1, 3'd1, 4'd1, 1, 3, 1'b0, 2'b00);
        push(8'h10, 1'b1, 8'hD2, 1'b1, 3'd1, 4'd2, 1, 3, 1'b0, 2'b00);
        for (int i = 0; i < 2; i++) push_rd(i, 1, 3, 1'b0, 2'b00);
        run_sb();
        chk("err_cleared_by_reset", 32'(out_timeout_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
